// File: rtl/id_ex_pkg.sv
// id_ex_pkg: shared definitions for the ID/EX pipeline register.
//   - default widths DATA_W / REG_AW / CTRL_W
//   - bit positions of the fields inside the opaque control bundle
//   - id_ex_payload_t: packed layout of one held instruction
//   - sb_state_e: skid-buffer occupancy, encoded as {main_valid, skid_valid}
package id_ex_pkg;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;
   localparam int CTRL_W = 12;

   // Control bundle field positions (the register only carries them).
   localparam int CTRL_ALUOP_LSB = 0;   // 4 bits
   localparam int CTRL_ALUOP_W   = 4;
   localparam int CTRL_ALUSRC    = 4;
   localparam int CTRL_REGDST    = 5;
   localparam int CTRL_REGWRITE  = 6;
   localparam int CTRL_MEMREAD   = 7;
   localparam int CTRL_MEMWRITE  = 8;
   localparam int CTRL_MEMTOREG  = 9;
   localparam int CTRL_BRANCH    = 10;
   localparam int CTRL_JUMP      = 11;

   typedef struct packed {
      logic [DATA_W-1:0] pc4;
      logic [DATA_W-1:0] rs_data;
      logic [DATA_W-1:0] rt_data;
      logic [DATA_W-1:0] imm;
      logic [REG_AW-1:0] rt_addr;
      logic [REG_AW-1:0] rd_addr;
      logic [CTRL_W-1:0] ctrl;
   } id_ex_payload_t;

   localparam int PAYLOAD_W = $bits(id_ex_payload_t);

   // State is the pair of valid bits itself; 2'b01 is unreachable.
   typedef enum logic [1:0] {
      SB_EMPTY = 2'b00,
      SB_ONE   = 2'b10,
      SB_FULL  = 2'b11
   } sb_state_e;

endpackage

// File: rtl/skid_buf_2e.sv
// skid_buf_2e: generic two-entry valid/ready skid buffer.
//   clk, rst (async, active high)
//   clr        : synchronous clear of both valid bits; same-cycle input dropped
//   in_valid/in_ready/in_data   : upstream side; in_ready is a flop output
//   out_valid/out_ready/out_data: downstream side, driven by the main entry
// in_ready depends only on state, so downstream stalls never reach upstream
// combinationally; the skid entry absorbs the one in-flight transfer.
module skid_buf_2e
   import id_ex_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   sb_state_e    state, state_nxt;
   logic [W-1:0] main_q, skid_q;
   logic         main_ld, main_from_skid, skid_ld;
   logic         accept, drain;

   assign out_valid = state[1];
   assign in_ready  = ~state[0];
   assign out_data  = main_q;
   assign accept    = in_valid & in_ready;
   assign drain     = out_valid & out_ready;

   always_comb begin
      state_nxt      = state;
      main_ld        = 1'b0;
      main_from_skid = 1'b0;
      skid_ld        = 1'b0;
      case (state)
         SB_EMPTY: begin
            if (accept) begin
               main_ld   = 1'b1;
               state_nxt = SB_ONE;
            end
         end
         SB_ONE: begin
            if (accept && drain) begin
               main_ld = 1'b1;
            end else if (accept) begin
               skid_ld   = 1'b1;
               state_nxt = SB_FULL;
            end else if (drain) begin
               state_nxt = SB_EMPTY;
            end
         end
         SB_FULL: begin
            if (drain) begin
               main_from_skid = 1'b1;
               state_nxt      = SB_ONE;
            end
         end
         default: state_nxt = SB_EMPTY;
      endcase
      // Clear wins: valids drop, payload keeps stale contents.
      if (clr) begin
         state_nxt      = SB_EMPTY;
         main_ld        = 1'b0;
         main_from_skid = 1'b0;
         skid_ld        = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= SB_EMPTY;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (main_ld)             main_q <= in_data;
         else if (main_from_skid) main_q <= skid_q;
         if (skid_ld)             skid_q <= in_data;
      end
   end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with valid/ready handshake,
// two-entry skid buffer and synchronous flush for branch redirect.
//   clk_i, rst_i (async, active high), flush_i
//   in_valid_i / in_ready_o, pc4_i, rs_data_i, rt_data_i, imm_i,
//   rt_addr_i, rd_addr_i, ctrl_i                  : decode side
//   out_valid_o / out_ready_i, pc4_o, rs_data_o, rt_data_o, imm_o,
//   rt_addr_o, rd_addr_o, ctrl_o                  : execute side
// Optional: define ID_EX_STALL_CNT_EN to add stall_cnt_o[15:0], a saturating
// count of cycles with out_valid_o & !out_ready_i (cleared by rst_i only).
module id_ex_pipe_reg #(
   parameter int DATA_W = id_ex_pkg::DATA_W,
   parameter int REG_AW = id_ex_pkg::REG_AW,
   parameter int CTRL_W = id_ex_pkg::CTRL_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] pc4_i,
   input  logic [DATA_W-1:0] rs_data_i,
   input  logic [DATA_W-1:0] rt_data_i,
   input  logic [DATA_W-1:0] imm_i,
   input  logic [REG_AW-1:0] rt_addr_i,
   input  logic [REG_AW-1:0] rd_addr_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] pc4_o,
   output logic [DATA_W-1:0] rs_data_o,
   output logic [DATA_W-1:0] rt_data_o,
   output logic [DATA_W-1:0] imm_o,
   output logic [REG_AW-1:0] rt_addr_o,
   output logic [REG_AW-1:0] rd_addr_o,
   output logic [CTRL_W-1:0] ctrl_o
`ifdef ID_EX_STALL_CNT_EN
   ,
   output logic [15:0]       stall_cnt_o
`endif
);

   // Same field order as id_ex_pkg::id_ex_payload_t.
   localparam int PAY_W = 4*DATA_W + 2*REG_AW + CTRL_W;

   logic [PAY_W-1:0] pay_in, pay_out;

   assign pay_in = {pc4_i, rs_data_i, rt_data_i, imm_i, rt_addr_i, rd_addr_i, ctrl_i};
   assign {pc4_o, rs_data_o, rt_data_o, imm_o, rt_addr_o, rd_addr_o, ctrl_o} = pay_out;

   skid_buf_2e #(.W(PAY_W)) u_skid (
      .clk       (clk_i),
      .rst       (rst_i),
      .clr       (flush_i),
      .in_valid  (in_valid_i),
      .in_ready  (in_ready_o),
      .in_data   (pay_in),
      .out_valid (out_valid_o),
      .out_ready (out_ready_i),
      .out_data  (pay_out)
   );

`ifdef ID_EX_STALL_CNT_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         stall_cnt_o <= 16'h0000;
      else if (out_valid_o && !out_ready_i && stall_cnt_o != 16'hFFFF)
         stall_cnt_o <= stall_cnt_o + 16'd1;
   end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg. Reference model: a FIFO queue of
// at most two payloads; out side shows the queue head, in_ready means room.
module tb_id_ex_pipe_reg;
   import id_ex_pkg::*;

   localparam int PW = 4*DATA_W + 2*REG_AW + CTRL_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              flush = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] pc4 = '0, rs_data = '0, rt_data = '0, imm = '0;
   logic [REG_AW-1:0] rt_addr = '0, rd_addr = '0;
   logic [CTRL_W-1:0] ctrl = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] pc4_o, rs_data_o, rt_data_o, imm_o;
   logic [REG_AW-1:0] rt_addr_o, rd_addr_o;
   logic [CTRL_W-1:0] ctrl_o;
`ifdef ID_EX_STALL_CNT_EN
   logic [15:0]       stall_cnt;
`endif

   logic [PW-1:0] dut_pay, in_pay;
   assign dut_pay = {pc4_o, rs_data_o, rt_data_o, imm_o, rt_addr_o, rd_addr_o, ctrl_o};
   assign in_pay  = {pc4, rs_data, rt_data, imm, rt_addr, rd_addr, ctrl};

   id_ex_pipe_reg dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .pc4_i       (pc4),
      .rs_data_i   (rs_data),
      .rt_data_i   (rt_data),
      .imm_i       (imm),
      .rt_addr_i   (rt_addr),
      .rd_addr_i   (rd_addr),
      .ctrl_i      (ctrl),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .pc4_o       (pc4_o),
      .rs_data_o   (rs_data_o),
      .rt_data_o   (rt_data_o),
      .imm_o       (imm_o),
      .rt_addr_o   (rt_addr_o),
      .rd_addr_o   (rd_addr_o),
      .ctrl_o      (ctrl_o)
`ifdef ID_EX_STALL_CNT_EN
      ,
      .stall_cnt_o (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [PW-1:0] q[$];
   int unsigned model_cnt = 0;

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [DATA_W-1:0] im);
      in_valid = v;
      imm      = im;
      pc4      = $urandom;
      rs_data  = $urandom;
      rt_data  = $urandom;
      rt_addr  = REG_AW'($urandom);
      rd_addr  = REG_AW'($urandom);
      ctrl     = CTRL_W'($urandom);
   endtask

   // Compare pre-edge outputs with the model, clock once, advance the model.
   task automatic step();
      logic acc, drn;
      chk("out_valid", out_valid, q.size() > 0);
      chk("in_ready", in_ready, q.size() < 2);
      chk("legal_state", out_valid | in_ready, 1'b1);
      if (q.size() > 0) chk("payload", dut_pay, q[0]);
`ifdef ID_EX_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, model_cnt[15:0]);
`endif
      acc = in_valid && (q.size() < 2);
      drn = (q.size() > 0) && out_ready;
      if (q.size() > 0 && !out_ready && model_cnt < 32'hFFFF) model_cnt++;
      @(posedge clk);
      #1;
      if (drn) void'(q.pop_front());
      if (flush) q.delete();
      else if (acc) q.push_back(in_pay);
   endtask

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_payload", dut_pay, '0);
      rst = 1'b0;

      // streaming, no bubbles
      out_ready = 1'b1;
      for (int n = 0; n < 8; n++) begin
         drive(1'b1, 32'hFFFF_FFF0 + n);
         step();
         chk("stream_valid", out_valid, 1'b1);
         chk("stream_imm", imm_o, 32'hFFFF_FFF0 + n);
      end
      drive(1'b0, '0);
      step();
      step();

      // backpressure into FULL and release
      drive(1'b1, 32'h0000_1234);
      step();
      out_ready = 1'b0;
      drive(1'b1, 32'hFFFF_8000);
      step();
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_imm_hold", imm_o, 32'h0000_1234);
      drive(1'b1, 32'hDEAD_BEEF);
      step();
      chk("bp_imm_hold2", imm_o, 32'h0000_1234);
      out_ready = 1'b1;
      drive(1'b0, '0);
      step();
      chk("bp_imm_next", imm_o, 32'hFFFF_8000);
      chk("bp_ready_back", in_ready, 1'b1);
      // drain to empty
      step();
      chk("drain_empty", out_valid, 1'b0);

      // flush while FULL with a same-cycle input
      out_ready = 1'b0;
      drive(1'b1, 32'h1111_0001);
      step();
      drive(1'b1, 32'h1111_0002);
      step();
      flush = 1'b1;
      drive(1'b1, 32'h0BAD_0BAD);
      step();
      flush = 1'b0;
      drive(1'b0, '0);
      chk("flush_valid", out_valid, 1'b0);
      chk("flush_ready", in_ready, 1'b1);
      out_ready = 1'b1;
      repeat (3) step();

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         drive(($urandom % 4) != 0, $urandom);
         out_ready = ($urandom % 3) != 0;
         flush     = ($urandom % 16) == 0;
         step();
      end
      flush = 1'b0;

      // asynchronous reset mid-cycle
      out_ready = 1'b0;
      drive(1'b1, 32'h5555_AAAA);
      step();
      drive(1'b0, '0);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_valid", out_valid, 1'b0);
      chk("async_rst_ready", in_ready, 1'b1);
      chk("async_rst_imm", imm_o, 32'h0);
      q.delete();
      model_cnt = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      step();

`ifdef ID_EX_STALL_CNT_EN
      // saturating stall counter, unaffected by flush
      drive(1'b1, 32'h0000_00AA);
      step();
      drive(1'b0, '0);
      repeat (70000) step();
      chk("stall_sat", stall_cnt, 16'hFFFF);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("stall_after_flush", stall_cnt, 16'hFFFF);
      chk("stall_flush_valid", out_valid, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Pipeline register between the decode stage (register file, sign-extension unit, control decoder) and the execute stage (ALU source mux, ALU, branch adder).
- Captures one decoded instruction per transfer: PC+4, both register operands, the 32-bit extended immediate, destination register candidates and control bundle.
- Uses a valid/ready handshake with a two-entry skid buffer, so a stall from execute never forms a combinational path back into decode.
- Supports a synchronous flush for branch redirect.

Parameters:
- DATA_W, 32, width of PC+4, operands and extended immediate
- REG_AW, 5, register-address width
- CTRL_W, 12, width of the opaque control bundle (ALU op, ALUSrc, RegDst, RegWrite, MemRead, MemWrite, MemtoReg, Branch, ...)

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  asynchronous, active-high reset
- flush_i  in  1  discard all held entries and any same-cycle input
- in_valid_i  in  1  decode presents an instruction
- in_ready_o  out  1  block can accept; equals NOT skid_valid (register-driven only)
- pc4_i  in  DATA_W  PC+4 of the instruction
- rs_data_i  in  DATA_W  register-file read data, rs
- rt_data_i  in  DATA_W  register-file read data, rt
- imm_i  in  DATA_W  sign/zero-extended immediate from the extension unit
- rt_addr_i  in  REG_AW  rt field
- rd_addr_i  in  REG_AW  rd field
- ctrl_i  in  CTRL_W  control bundle
- out_valid_o  out  1  output entry valid
- out_ready_i  in  1  execute consumes the entry
- pc4_o, rs_data_o, rt_data_o, imm_o  out  DATA_W  registered copies
- rt_addr_o, rd_addr_o  out  REG_AW  registered copies
- ctrl_o  out  CTRL_W  registered copy

Behaviour:
- Storage:
  - main entry (drives outputs) and skid entry, each a payload plus a valid bit.
  - Payload = {pc4, rs_data, rt_data, imm, rt_addr, rd_addr, ctrl}.
- Reset, asynchronous, while rst_i=1:
  - main_valid=0, skid_valid=0, so out_valid_o=0 and in_ready_o=1.
  - All payload registers and therefore all data outputs = 0.
- Events per cycle:
  - accept = in_valid_i & in_ready_o
  - drain = out_valid_o & out_ready_i
- States are derived from the valid bits: EMPTY(0,0), ONE(1,0), FULL(1,1). The state (0,1) is illegal; the bench asserts it never occurs.
- Transitions when flush_i=0:
  - EMPTY: accept loads main, giving ONE. Otherwise stay EMPTY.
  - ONE, accept & drain: main <= input, stay ONE.
  - ONE, accept & !drain: skid <= input, go to FULL.
  - ONE, !accept & drain: main_valid <= 0, go to EMPTY.
  - ONE, neither: hold.
  - FULL (in_ready_o=0, so accept is impossible), drain: main <= skid, skid_valid <= 0, go to ONE.
  - FULL, !drain: hold.
- flush_i=1 (priority over everything):
  - Next state is EMPTY.
  - Any same-cycle accept is dropped.
  - A same-cycle drain still counts as consumed by execute.
  - Payload registers keep stale values; only the valid bits clear.
- Latency: one cycle from accept in EMPTY to out_valid_o=1. Sustained throughput is one instruction per cycle when out_ready_i=1.
- Outputs are stable while out_valid_o=1 and out_ready_i=0.
- Width rules: pure storage, no arithmetic. imm_i is stored bit-exact; extension has already been done upstream.
- Reset asserted mid-operation: entries are lost immediately. No partial-state recovery.

Optional Feature:
- Macro: ID_EX_STALL_CNT_EN
- Defined:
  - Adds output stall_cnt_o [15:0].
  - Increments every cycle out_valid_o & !out_ready_i.
  - Saturates at 16'hFFFF.
  - Cleared by rst_i only; flush_i does not clear it.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package id_ex_pkg holds:
  - localparams DATA_W, REG_AW, CTRL_W
  - the control-bundle field bit positions
  - a packed typedef id_ex_payload_t for the payload concatenation
- One natural sub-module: skid_buf_2e, a generic two-entry valid/ready skid buffer parameterised on payload width. id_ex_pipe_reg wraps it, adds flush, and packs/unpacks the fields.

Test Plan:
- Reset check: assert rst_i asynchronously mid-cycle -> out_valid_o=0, in_ready_o=1, imm_o=32'h0 immediately, without waiting for a clock edge.
- Streaming: in_valid_i=1 and out_ready_i=1 for 8 cycles, imm_i=32'hFFFF_FFF0+n -> out_valid_o from cycle 1, imm_o matches in order, no bubbles.
- Backpressure: in state ONE holding imm=32'h0000_1234, drop out_ready_i and accept imm=32'hFFFF_8000 -> FULL, in_ready_o=0, imm_o stays 32'h0000_1234. Raise out_ready_i -> imm_o=32'hFFFF_8000 next cycle, in_ready_o=1.
- Flush while FULL with in_valid_i=1 -> next cycle out_valid_o=0, in_ready_o=1; the flushed input never appears at the outputs.
- Drain to empty: ONE state, out_ready_i=1, in_valid_i=0 -> out_valid_o=0 next cycle. Payload outputs are don't-care after that.
- ID_EX_STALL_CNT_EN build: hold out_valid_o=1, out_ready_i=0 for 70000 cycles -> stall_cnt_o=16'hFFFF. Flush -> counter unchanged.
